map_loader: RTL and testbench

Fetches one sudoku puzzle, both solution digits and the initial visibility mask, from an external synchronous puzzle ROM. It does this cell by cell when the game enters its loading phase, and publishes the result atomically on the `selected_map`/`selected_visibility` buses read by the game state machine. Until a complete, valid puzzle has been assembled, `selected_visibility` stays all-zero, so the game remains in its loading state.

---
 rtl/map_loader.sv | 161 ++++++++++++++++
 tb/tb_map_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_loader.sv
// map_loader: fetches one sudoku puzzle from a registered puzzle ROM
// and publishes solution digits and visibility mask atomically.
module map_loader #(
    parameter int NUM_PUZZLES = 4,
    parameter int ADDR_W      = 10,
    localparam int PID_W =
        (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              difficulty,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [323:0]      selected_map,
    output logic [80:0]       selected_visibility,
    output logic [PID_W-1:0]  puzzle_id,
    output logic              busy,
    output logic              done,
    output logic              load_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              diff_q, diff_d;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic [PID_W-1:0]  sel_q, sel_d;
    logic              bad_q, bad_d;
    logic [323:0]      map_sh_q, map_sh_d;
    logic [80:0]       vis_sh_q, vis_sh_d;
    logic [323:0]      map_q, map_d;
    logic [80:0]       vis_q, vis_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [6:0]        idx;
    logic [ADDR_W-1:0] base;

    assign busy                = (state_q != S_IDLE);
    assign done                = done_q;
    assign load_error          = err_q;
    assign selected_map        = map_q;
    assign selected_visibility = vis_q;
    assign puzzle_id           = pid_q;

    assign base = (ADDR_W'(diff_q) * ADDR_W'(NUM_PUZZLES)
                   + ADDR_W'(pid_q)) * ADDR_W'(81);

    // Free-running puzzle selector, wraps at NUM_PUZZLES-1.
    always_comb begin
        sel_d = sel_q + 1'b1;
        if (sel_q == PID_W'(NUM_PUZZLES - 1)) begin
            sel_d = '0;
        end
    end

    // ROM address: counter is held at 80 for the final capture cycle.
    always_comb begin
        rom_addr = '0;
        if (state_q == S_FILL) begin
            rom_addr = base + ((cnt_q > 7'd80) ? ADDR_W'(80)
                                               : ADDR_W'(cnt_q));
        end
    end

    // Next-state, shadow capture, validation and publish.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        pid_d    = pid_q;
        bad_d    = bad_q;
        map_sh_d = map_sh_q;
        vis_sh_d = vis_sh_q;
        map_d    = map_q;
        vis_d    = vis_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        idx      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d  = S_FILL;
                    diff_d   = difficulty;
                    pid_d    = sel_q;
                    cnt_d    = '0;
                    bad_d    = 1'b0;
                    map_sh_d = '0;
                    vis_sh_d = '0;
                    map_d    = '0;
                    vis_d    = '0;
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q != 7'd0) begin
                    idx = cnt_q - 7'd1;
                    map_sh_d[{idx, 2'b00} +: 4] = rom_data[3:0];
                    vis_sh_d[idx] = rom_data[4];
                    if (rom_data[3:0] == 4'd0 ||
                        rom_data[3:0] > 4'd9) begin
                        bad_d = 1'b1;
                    end
                end
                if (cnt_q == 7'd81) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!bad_q && (|vis_sh_q)) begin
                    map_d  = map_sh_q;
                    vis_d  = vis_sh_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            diff_q   <= 1'b0;
            pid_q    <= '0;
            sel_q    <= '0;
            bad_q    <= 1'b0;
            map_sh_q <= '0;
            vis_sh_q <= '0;
            map_q    <= '0;
            vis_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            pid_q    <= pid_d;
            sel_q    <= sel_d;
            bad_q    <= bad_d;
            map_sh_q <= map_sh_d;
            vis_sh_q <= vis_sh_d;
            map_q    <= map_d;
            vis_q    <= vis_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// tb_map_loader: randomized bench for map_loader with a puzzle-level
// reference model and per-cycle output comparison.
module tb_map_loader;

    localparam int NP = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic          difficulty = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [4:0]    rom_data;
    logic [323:0]  selected_map;
    logic [80:0]   selected_visibility;
    logic [1:0]    puzzle_id;
    logic          busy;
    logic          done;
    logic          load_error;

    logic [4:0]    rom [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    map_loader #(.NUM_PUZZLES(NP), .ADDR_W(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .load                (load),
        .difficulty          (difficulty),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .selected_map        (selected_map),
        .selected_visibility (selected_visibility),
        .puzzle_id           (puzzle_id),
        .busy                (busy),
        .done                (done),
        .load_error          (load_error)
    );

    // Registered puzzle ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [323:0] act,
                       input logic [323:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int base_of(input bit d, input int p);
        return (int'(d) * NP + p) * 81;
    endfunction

    // Whole-puzzle verdict straight from ROM contents.
    function automatic void ref_puzzle(input int b,
                                       output logic [323:0] mp,
                                       output logic [80:0] vs,
                                       output bit ok);
        logic [4:0] w;
        mp = '0;
        vs = '0;
        ok = 1'b1;
        for (int k = 0; k < 81; k++) begin
            w = rom[b + k];
            mp[4*k +: 4] = w[3:0];
            vs[k] = w[4];
            if (w[3:0] == 4'd0 || w[3:0] > 4'd9) ok = 1'b0;
        end
        if (vs == '0) ok = 1'b0;
    endfunction

    // Reference model: m_t = cycles since acceptance, 0 when idle.
    int           m_t = 0;
    int           m_sel = 0;
    bit           m_diff = 1'b0;
    int           m_pid = 0;
    logic [323:0] m_map = '0;
    logic [80:0]  m_vis = '0;
    bit           m_done = 1'b0;
    bit           m_err = 1'b0;
    logic [323:0] t_mp;
    logic [80:0]  t_vs;
    bit           t_ok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t    <= 0;
            m_sel  <= 0;
            m_diff <= 1'b0;
            m_pid  <= 0;
            m_map  <= '0;
            m_vis  <= '0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_sel  <= (m_sel + 1) % NP;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_t == 0) begin
                if (load) begin
                    m_t    <= 1;
                    m_diff <= difficulty;
                    m_pid  <= m_sel;
                    m_map  <= '0;
                    m_vis  <= '0;
                end
            end else if (m_t < 83) begin
                m_t <= m_t + 1;
            end else begin
                m_t <= 0;
                ref_puzzle(base_of(m_diff, m_pid), t_mp, t_vs, t_ok);
                if (t_ok) begin
                    m_map  <= t_mp;
                    m_vis  <= t_vs;
                    m_done <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    // Compare DUT to model every cycle, away from the active edge.
    always @(negedge clk) begin : cmp
        int ea;
        ea = 0;
        if (m_t >= 1 && m_t <= 82) begin
            ea = base_of(m_diff, m_pid) + ((m_t - 1 > 80) ? 80 : m_t - 1);
        end
        chk("busy", busy, m_t != 0);
        chk("done", done, m_done);
        chk("load_error", load_error, m_err);
        chk("rom_addr", rom_addr, ea);
        chk("puzzle_id", puzzle_id, m_pid);
        chk("selected_map", selected_map, m_map);
        chk("selected_visibility", selected_visibility, m_vis);
    end

    int            lat;
    bit            got_err;
    bit            seq_ok;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    logic [80:0]   vis1;

    task automatic fill_valid(input int b);
        for (int k = 0; k < 81; k++) begin
            rom[b + k] = {1'($urandom_range(0, 1)),
                          4'($urandom_range(1, 9))};
        end
        rom[b + $urandom_range(0, 80)][4] = 1'b1;
    endtask

    // One load; lat = edges from acceptance to pulse, -1 timeout,
    // -2 when reset was applied mid-fill.
    task automatic run_load(input bit d, input int want_pid,
                            input int pulse_at, input int rst_at);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(m_t == 0 && (want_pid < 0 || m_sel == want_pid))
               && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        load = 1'b1;
        difficulty = d;
        lat = -1;
        got_err = 1'b0;
        seq_ok = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            load = (i == pulse_at);
            difficulty = 1'($urandom_range(0, 1));
            if (i == 1) begin
                vis1 = selected_visibility;
                a_first = rom_addr;
            end
            if (i <= 81 && rom_addr !== a_first + AW'(i - 1)) begin
                seq_ok = 1'b0;
            end
            if (i == 81) a_last = rom_addr;
            if (i == rst_at) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
                lat = -2;
                break;
            end
            if (done || load_error) begin
                lat = i - 1;
                got_err = load_error;
                break;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        int b;
        int guard;
        int pid;
        bit d;
        for (int k = 0; k < 1024; k++) rom[k] = 5'($urandom);

        // Reset with random ROM contents.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_map", selected_map, 0);
        chk("rst_vis", selected_visibility, 0);
        chk("rst_pulses", {done, load_error}, 0);
        #2 reset = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("accept_after_rst", busy, 1);
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_load_ends", busy, 0);

        for (int p = 0; p < 2 * NP; p++) fill_valid(p * 81);

        // Nominal: difficulty 1, puzzle 2 -> base 486.
        for (int k = 0; k < 81; k++) begin
            rom[486 + k] = {1'(k % 2), 4'((k % 9) + 1)};
        end
        run_load(1'b1, 2, 0, 0);
        chk("nom_latency", lat, 83);
        chk("nom_pulse_done", got_err, 0);
        chk("nom_addr_first", a_first, 486);
        chk("nom_addr_last", a_last, 566);
        chk("nom_addr_seq", seq_ok, 1);
        chk("nom_pid", puzzle_id, 2);
        chk("nom_map_lo", selected_map[3:0], 1);
        chk("nom_map_hi", selected_map[323:320], 9);
        chk("nom_vis", selected_visibility,
            81'h0_AAAA_AAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        chk("nom_busy_after", busy, 0);
        chk("nom_done_1cyc", done, 0);

        // Reissue: load pulsed mid-fill, buses clear then republish.
        run_load(1'b0, 1, 30, 0);
        chk("reissue_clear", vis1, 0);
        chk("reissue_latency", lat, 83);
        chk("reissue_done", got_err, 0);

        // Bad digit in cell 40.
        b = base_of(1'b0, 3);
        rom[b + 40][3:0] = 4'd0;
        run_load(1'b0, 3, 0, 0);
        chk("bad_latency", lat, 83);
        chk("bad_err", got_err, 1);
        chk("bad_map", selected_map, 0);
        chk("bad_vis", selected_visibility, 0);
        fill_valid(b);

        // Empty mask.
        b = base_of(1'b1, 0);
        for (int k = 0; k < 81; k++) rom[b + k][4] = 1'b0;
        run_load(1'b1, 0, 0, 0);
        chk("empty_latency", lat, 83);
        chk("empty_err", got_err, 1);
        chk("empty_vis", selected_visibility, 0);
        fill_valid(b);

        // Reset in the middle of a fill, then a clean load.
        run_load(1'b1, 1, 0, 50);
        chk("midrst_no_pulse", lat, -2);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_vis", selected_visibility, 0);
        chk("midrst_map", selected_map, 0);
        chk("midrst_pid", puzzle_id, 0);
        run_load(1'b1, 1, 0, 0);
        chk("postrst_latency", lat, 83);
        chk("postrst_done", got_err, 0);

        // Randomized loads with occasional corruption.
        for (int n = 0; n < 14; n++) begin
            d = 1'($urandom_range(0, 1));
            pid = $urandom_range(0, NP - 1);
            b = base_of(d, pid);
            fill_valid(b);
            if ($urandom_range(0, 3) == 0) begin
                int w;
                w = $urandom_range(0, 6);
                rom[b + $urandom_range(0, 80)][3:0] =
                    (w == 0) ? 4'd0 : 4'(9 + w);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 81; k++) rom[b + k][4] = 1'b0;
            end
            run_load(d, pid,
                     ($urandom_range(0, 1) == 1) ?
                     $urandom_range(2, 82) : 0, 0);
            chk("rand_latency", lat, 83);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
